// File: rtl/generator_faz_rozrzadu_if.sv
// generator_faz_rozrzadu_if: crank step/sync inputs, eight angle thresholds and the
// valve, injector and spark drive outputs of the timing generator.
interface generator_faz_rozrzadu_if #(
    parameter int SZER_KATA = 10
);
    logic                 krok_kata;
    logic                 synchro;
    logic [SZER_KATA-1:0] stopnie_zaswiecenie_ssacy;
    logic [SZER_KATA-1:0] stopnie_zgaszenie_ssacy;
    logic [SZER_KATA-1:0] stopnie_zaswiecenie_wydechowy;
    logic [SZER_KATA-1:0] stopnie_zgaszenie_wydechowy;
    logic [SZER_KATA-1:0] stopnie_zaswiecenie_wtrysk;
    logic [SZER_KATA-1:0] stopnie_zgaszenie_wtrysk;
    logic [SZER_KATA-1:0] stopnie_zaswiecenie_iskra;
    logic [SZER_KATA-1:0] stopnie_zgaszenie_iskra;
    logic                 zawor_ssacy;
    logic                 zawor_wydechowy;
    logic                 wtrysk;
    logic                 iskra;
    logic [SZER_KATA-1:0] kat;
    logic                 zsynchronizowany;
    logic                 postoj;

    modport master (
        output krok_kata, synchro,
        output stopnie_zaswiecenie_ssacy, stopnie_zgaszenie_ssacy,
        output stopnie_zaswiecenie_wydechowy, stopnie_zgaszenie_wydechowy,
        output stopnie_zaswiecenie_wtrysk, stopnie_zgaszenie_wtrysk,
        output stopnie_zaswiecenie_iskra, stopnie_zgaszenie_iskra,
        input  zawor_ssacy, zawor_wydechowy, wtrysk, iskra,
        input  kat, zsynchronizowany, postoj
    );

    modport slave (
        input  krok_kata, synchro,
        input  stopnie_zaswiecenie_ssacy, stopnie_zgaszenie_ssacy,
        input  stopnie_zaswiecenie_wydechowy, stopnie_zgaszenie_wydechowy,
        input  stopnie_zaswiecenie_wtrysk, stopnie_zgaszenie_wtrysk,
        input  stopnie_zaswiecenie_iskra, stopnie_zgaszenie_iskra,
        output zawor_ssacy, zawor_wydechowy, wtrysk, iskra,
        output kat, zsynchronizowany, postoj
    );
endinterface

// File: rtl/generator_faz_rozrzadu.sv
// generator_faz_rozrzadu: crank-angle tracker over a 720-degree cycle gating intake,
// exhaust, injector and spark outputs by double-buffered on/off angle windows.
module generator_faz_rozrzadu #(
    parameter int STOPNIE_CYKLU = 720,
    parameter int SZER_KATA     = 10,
    parameter int LIMIT_POSTOJU = 1000000
) (
    input logic                     clk,
    input logic                     rst_n,
    generator_faz_rozrzadu_if.slave bus
);
    localparam int SZER_LICZ = $clog2(LIMIT_POSTOJU + 1);
    localparam logic [SZER_KATA-1:0] KAT_MAX = SZER_KATA'(STOPNIE_CYKLU - 1);
    localparam logic [SZER_LICZ-1:0] LIMIT = SZER_LICZ'(LIMIT_POSTOJU);

    logic [SZER_KATA-1:0] kat, kat_nast;
    logic [SZER_KATA-1:0] progi [8];
    logic [SZER_KATA-1:0] cien [8];
    logic [SZER_LICZ-1:0] licznik;
    logic                 zsync, postoj, zapis_zera;
    logic [3:0]           aktywny, wyj;

    assign progi[0] = bus.stopnie_zaswiecenie_ssacy;
    assign progi[1] = bus.stopnie_zgaszenie_ssacy;
    assign progi[2] = bus.stopnie_zaswiecenie_wydechowy;
    assign progi[3] = bus.stopnie_zgaszenie_wydechowy;
    assign progi[4] = bus.stopnie_zaswiecenie_wtrysk;
    assign progi[5] = bus.stopnie_zgaszenie_wtrysk;
    assign progi[6] = bus.stopnie_zaswiecenie_iskra;
    assign progi[7] = bus.stopnie_zgaszenie_iskra;

    // Out-of-range thresholds disable the channel; on > off is a window wrapping past 0.
    function automatic logic okno(input logic [SZER_KATA-1:0] k, a, b);
        logic poprawne;
        poprawne = 32'(a) < STOPNIE_CYKLU && 32'(b) < STOPNIE_CYKLU;
        return poprawne && (a < b ? k >= a && k < b : a > b && (k >= a || k < b));
    endfunction

    always_comb begin
        kat_nast   = bus.synchro ? '0 : !bus.krok_kata ? kat : kat == KAT_MAX ? '0 : kat + 1'b1;
        zapis_zera = bus.synchro || (bus.krok_kata && kat == KAT_MAX);
    end

    for (genvar c = 0; c < 4; c++) begin : g_kanal
        assign aktywny[c] = okno(kat, cien[2*c], cien[2*c+1]);
    end

    assign postoj = licznik == LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kat     <= '0;
            licznik <= '0;
            zsync   <= 1'b0;
            wyj     <= '0;
            for (int i = 0; i < 8; i++) cien[i] <= '0;
        end else begin
            kat     <= kat_nast;
            licznik <= bus.krok_kata ? '0 : postoj ? licznik : licznik + 1'b1;
            zsync   <= bus.synchro || (zsync && !postoj);
            wyj     <= zsync && !postoj ? aktywny : '0;
            if (zapis_zera) for (int i = 0; i < 8; i++) cien[i] <= progi[i];
        end
    end

    assign bus.kat              = kat;
    assign bus.zawor_ssacy      = wyj[0];
    assign bus.zawor_wydechowy  = wyj[1];
    assign bus.wtrysk           = wyj[2];
    assign bus.iskra            = wyj[3];
    assign bus.zsynchronizowany = zsync;
    assign bus.postoj           = postoj;
endmodule

// File: doc/generator_faz_rozrzadu.md
Name: generator_faz_rozrzadu

Overview:
- Consumes the eight angle thresholds produced by the valve-timing table block and drives the intake valve, exhaust valve, injector and spark outputs.
- Tracks crankshaft angle over a 720-degree four-stroke cycle using a per-degree step pulse and a cycle-start sync pulse.
- Gates each output within its on/off angle window, including windows that wrap past 0.
- Thresholds are double-buffered and switch only at cycle start, so a mid-cycle rpm band change never produces a truncated or glitched window.

Parameters:
- STOPNIE_CYKLU, 720, degrees per full engine cycle; angle counts 0..STOPNIE_CYKLU-1.
- SZER_KATA, 10, width of angle counter and threshold inputs.
- LIMIT_POSTOJU, 1000000, clocks without a krok_kata pulse before the engine is declared stalled.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- krok_kata  in  1  single-clk pulse per 1 degree of crank rotation.
- synchro  in  1  single-clk pulse marking cycle start (angle 0).
- stopnie_zaswiecenie_ssacy / stopnie_zgaszenie_ssacy  in  SZER_KATA  intake on/off angles.
- stopnie_zaswiecenie_wydechowy / stopnie_zgaszenie_wydechowy  in  SZER_KATA  exhaust on/off angles.
- stopnie_zaswiecenie_wtrysk / stopnie_zgaszenie_wtrysk  in  SZER_KATA  injector on/off angles.
- stopnie_zaswiecenie_iskra / stopnie_zgaszenie_iskra  in  SZER_KATA  spark on/off angles.
- zawor_ssacy, zawor_wydechowy, wtrysk, iskra  out  1  registered drive outputs.
- kat  out  SZER_KATA  current crank angle.
- zsynchronizowany  out  1  high once a synchro pulse has been seen and no stall has occurred since.
- postoj  out  1  high while the stall condition holds.

Behaviour:
- Reset (rst_n low, async): kat=0, all shadow thresholds=0, all drive outputs=0, zsynchronizowany=0, postoj=0, stall counter=0.

Angle counter (updated on clk):
- synchro=1: kat<=0, regardless of krok_kata. Synchro wins over a simultaneous step.
- Else if krok_kata=1: kat<=kat+1, wrapping STOPNIE_CYKLU-1 -> 0.
- Else kat holds.
- synchro arriving at any angle (early or late) realigns to 0; the counter never exceeds STOPNIE_CYKLU-1.

Shadow thresholds:
- All 8 inputs are latched into shadow registers in every cycle where kat is written to 0, by wrap or by synchro.
- Inputs have no effect at any other time.

Window decode (per channel, uses shadow on=A, off=B, angle=kat):
- A<B: active when A<=kat<B.
- A>B (wrapping): active when kat>=A or kat<B.
- A==B: never active.
- A or B >= STOPNIE_CYKLU: channel forced inactive.
- Output register <= active AND zsynchronizowany AND NOT postoj.
- Latency: outputs reflect the kat value registered one clk earlier (one cycle after the kat update).

Synchronisation and stall:
- zsynchronizowany sets on the first synchro after reset or after a stall.
- Stall counter resets to 0 on every krok_kata and otherwise increments, saturating at LIMIT_POSTOJU.
- When the counter reaches LIMIT_POSTOJU: postoj=1, zsynchronizowany=0, and all outputs go to 0 on the next clk.
- postoj clears on the next krok_kata. Outputs stay 0 until a new synchro arrives.
- While unsynchronised, kat still counts so that it remains observable.

Test Plan:
- Reset, synchro, then 720 steps with intake 160/406: zawor_ssacy rises one clk after kat=160, falls one clk after kat=406; high for exactly 246 steps.
- Exhaust 674/190 (wrapping): zawor_wydechowy high for kat 674..719 and 0..189, 236 steps total, with no glitch at the wrap.
- Change thresholds at kat=300 (spark 525/545 -> 515/555): current cycle still fires iskra at 525..544; the next cycle fires at 515..554.
- synchro and krok_kata asserted together at kat=500: kat=0 next clk, and shadows reload in that same cycle.
- Hold krok_kata low for LIMIT_POSTOJU clks mid-window (use a small parameter, e.g. 50): postoj=1, all outputs 0; a later step clears postoj but outputs stay 0 until the next synchro.
- Edge cases: on==off=250 never asserts; on=730 keeps the channel low; asserting rst_n low mid-window drops all outputs to 0 asynchronously.
